// File: rtl/uart_byte_receiver.sv
// UART 8N1 byte receiver: two-flop input synchronizer, mid-bit sampling
// framer, and registered good-byte / framing-error strobes.
module uart_byte_receiver #(
  parameter int unsigned CLKFRQ   = 100000000,
  parameter int unsigned BAUDRATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       receiveAll,
  output logic       frameError,
  output logic       busy
);

  localparam int unsigned DIV  = CLKFRQ / BAUDRATE;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CntW = $clog2(DIV);

  localparam logic [CntW-1:0] CntFull = CntW'(DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(HALF - 1);

  // Below four clocks per bit the half-bit point and counter width break down.
  if (DIV < 4) begin : genBadConfig
    $error("uart_byte_receiver: CLKFRQ/BAUDRATE must be at least 4");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } stateType;

  stateType        state;
  logic [CntW-1:0] cnt;
  logic [2:0]      idx;
  logic [7:0]      sh;
  logic            rxSync;
  logic            rxS;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxSync <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxSync <= rx;
      rxS    <= rxSync;
    end
  end

  // Framing FSM with registered strobes; cnt is zeroed on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      data       <= '0;
      receiveAll <= 1'b0;
      frameError <= 1'b0;
    end else begin
      receiveAll <= 1'b0;
      frameError <= 1'b0;
      case (state)
        StIdle: begin
          cnt <= '0;
          if (!rxS) begin
            state <= StStart;
          end
        end
        StStart: begin
          if (cnt == CntHalf) begin
            cnt <= '0;
            if (!rxS) begin
              state <= StData;
              idx   <= '0;
            end else begin
              // Start bit vanished before mid-bit: a glitch, not a frame.
              state <= StIdle;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StData: begin
          if (cnt == CntFull) begin
            cnt <= '0;
            sh  <= {rxS, sh[7:1]};
            idx <= idx + 1'b1;
            if (idx == 3'd7) begin
              state <= StStop;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StStop: begin
          if (cnt == CntFull) begin
            cnt <= '0;
            if (rxS) begin
              data       <= sh;
              receiveAll <= 1'b1;
              state      <= StIdle;
            end else begin
              frameError <= 1'b1;
              state      <= StBreak;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StBreak: begin
          // Hold off until the line is idle so a break cannot re-trigger.
          cnt <= '0;
          if (rxS) begin
            state <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Busy is a pure decode of the state register.
  always_comb begin
    busy = (state != StIdle);
  end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Self-checking bench for uart_byte_receiver: table-driven frames, hand-written
// corner sequences, and per-instance scoreboards of expected bytes.
module tb_uart_byte_receiver;

  localparam int DivA  = 16;
  localparam int HalfA = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rxB;
  logic [7:0] dataA, dataB;
  logic       receiveAllA, receiveAllB;
  logic       frameErrorA, frameErrorB;
  logic       busyA, busyB;

  always #5 clk = ~clk;

  uart_byte_receiver #(.CLKFRQ(16), .BAUDRATE(1)) dutA (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (dataA),
    .receiveAll (receiveAllA),
    .frameError (frameErrorA),
    .busy       (busyA)
  );

  // Short-divider stand-in for the default rate so the +/-4% run stays brief.
  uart_byte_receiver #(.CLKFRQ(100000000), .BAUDRATE(100000)) dutB (
    .clk        (clk),
    .reset      (reset),
    .rx         (rxB),
    .data       (dataB),
    .receiveAll (receiveAllB),
    .frameError (frameErrorB),
    .busy       (busyB)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] expQA[$];
  logic [7:0] expQB[$];
  logic [7:0] expA, expB;
  int rxCntA = 0, feCntA = 0, rxCntB = 0, feCntB = 0;
  int busyHiA = 0, busyRiseA = 0, strobeCycA = 0;
  logic busyPrevA = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame, LSB first, onto rx (toB = 0) or rxB (toB = 1).
  task automatic sendFrame(input bit toB, input logic [7:0] value, input logic stopBit,
                           input int bitTime);
    logic [9:0] bits;
    bits = {stopBit, value, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (toB) rxB = bits[i];
      else     rx  = bits[i];
      tick(bitTime);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and strobe/busy bookkeeping for instance A.
  always @(negedge clk) begin
    if (receiveAllA) begin
      rxCntA++;
      strobeCycA = cyc;
      if (expQA.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL strobeA_unexpected: data %0h, expected no strobe", dataA);
      end else begin
        expA = expQA.pop_front();
        check("dataA_scoreboard", {24'h0, dataA}, {24'h0, expA});
      end
    end
    if (frameErrorA) feCntA++;
    if (receiveAllA && frameErrorA) begin
      tests++;
      fails++;
      $display("FAIL strobesA_together: receiveAll=1 frameError=1, expected not both");
    end
    if (busyA === 1'b1) busyHiA++;
    if (busyA === 1'b1 && busyPrevA !== 1'b1) busyRiseA = cyc;
    busyPrevA = busyA;
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (receiveAllB) begin
      rxCntB++;
      if (expQB.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL strobeB_unexpected: data %0h, expected no strobe", dataB);
      end else begin
        expB = expQB.pop_front();
        check("dataB_scoreboard", {24'h0, dataB}, {24'h0, expB});
      end
    end
    if (frameErrorB) feCntB++;
  end

  typedef struct {
    logic [7:0] value;
    logic       stopBit;
    int         expRx;
    int         expFe;
    logic [7:0] expData;
  } vecType;

  vecType vecs[6];

  initial begin
    int rb, fb;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 0, 1, 8'hFF};
    vecs[4] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
    vecs[5] = '{8'h81, 1'b1, 1, 0, 8'h81};

    reset = 1'b1;
    rx    = 1'b1;
    rxB   = 1'b1;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    check("reset_dataA", {24'h0, dataA}, 32'h0);
    check("reset_receiveAllA", {31'h0, receiveAllA}, 32'h0);
    check("reset_frameErrorA", {31'h0, frameErrorA}, 32'h0);
    check("reset_busyA", {31'h0, busyA}, 32'h0);
    check("reset_dataB", {24'h0, dataB}, 32'h0);
    check("reset_busyB", {31'h0, busyB}, 32'h0);
    tick(4);

    // Table: single frames with idle gaps, including one bad stop bit.
    for (int i = 0; i < 6; i++) begin
      rb = rxCntA;
      fb = feCntA;
      if (vecs[i].stopBit) expQA.push_back(vecs[i].value);
      sendFrame(1'b0, vecs[i].value, vecs[i].stopBit, DivA);
      rx = 1'b1;
      tick(24);
      check("tbl_rx_count", rxCntA - rb, vecs[i].expRx);
      check("tbl_fe_count", feCntA - fb, vecs[i].expFe);
      check("tbl_data", {24'h0, dataA}, {24'h0, vecs[i].expData});
      check("tbl_busy_idle", {31'h0, busyA}, 32'h0);
      if (vecs[i].expRx == 1) begin
        // Busy rises at t0+1, strobe at t0+HALF+9*DIV+1.
        check("tbl_strobe_latency", strobeCycA - busyRiseA, HalfA + 9 * DivA);
      end
    end

    // Ten back-to-back frames with a single stop bit each.
    rb = rxCntA;
    for (int i = 0; i < 10; i++) begin
      expQA.push_back(8'(i));
      sendFrame(1'b0, 8'(i), 1'b1, DivA);
    end
    tick(24);
    check("b2b_rx_count", rxCntA - rb, 10);
    check("b2b_last_data", {24'h0, dataA}, 32'h09);

    // Five-cycle low glitch on an idle line.
    rb = rxCntA;
    fb = feCntA;
    busyHiA = 0;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(40);
    check("glitch_busy_cycles", busyHiA, HalfA);
    check("glitch_no_rx", rxCntA - rb, 0);
    check("glitch_no_fe", feCntA - fb, 0);
    check("glitch_busy_idle", {31'h0, busyA}, 32'h0);

    // Bad stop bit followed by a 100-cycle break, then a good frame.
    rb = rxCntA;
    fb = feCntA;
    sendFrame(1'b0, 8'h3C, 1'b0, DivA);
    tick(100);
    @(negedge clk);
    check("break_busy_held", {31'h0, busyA}, 32'h1);
    check("break_fe_once", feCntA - fb, 1);
    check("break_data_kept", {24'h0, dataA}, 32'h09);
    tick(1);
    rx = 1'b1;
    tick(6);
    check("break_busy_released", {31'h0, busyA}, 32'h0);
    expQA.push_back(8'h7E);
    sendFrame(1'b0, 8'h7E, 1'b1, DivA);
    tick(24);
    check("after_break_rx", rxCntA - rb, 1);
    check("after_break_fe", feCntA - fb, 1);
    check("after_break_data", {24'h0, dataA}, 32'h7E);

    // Reset pulse in the middle of data bit 4; remaining bits are all high.
    rb = rxCntA;
    fb = feCntA;
    fork
      sendFrame(1'b0, 8'hF0, 1'b1, DivA);
      begin
        tick(DivA * 5 + DivA / 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_busy", {31'h0, busyA}, 32'h0);
        check("midreset_data", {24'h0, dataA}, 32'h0);
      end
    join
    tick(24);
    check("midreset_no_rx", rxCntA - rb, 0);
    check("midreset_no_fe", feCntA - fb, 0);
    expQA.push_back(8'hFF);
    sendFrame(1'b0, 8'hFF, 1'b1, DivA);
    tick(24);
    check("postreset_rx", rxCntA - rb, 1);
    check("postreset_data", {24'h0, dataA}, 32'hFF);

    // Baud mismatch of -4% and +4% against a 1000-clock bit.
    rb = rxCntB;
    fb = feCntB;
    expQB.push_back(8'h55);
    sendFrame(1'b1, 8'h55, 1'b1, 960);
    tick(100);
    check("slow_clk_rx", rxCntB - rb, 1);
    check("slow_clk_data", {24'h0, dataB}, 32'h55);
    expQB.push_back(8'h55);
    sendFrame(1'b1, 8'h55, 1'b1, 1040);
    tick(100);
    check("fast_clk_rx", rxCntB - rb, 2);
    check("fast_clk_data", {24'h0, dataB}, 32'h55);
    check("mismatch_no_fe", feCntB - fb, 0);
    check("busyB_idle", {31'h0, busyB}, 32'h0);

    check("scoreboardA_drained", expQA.size(), 0);
    check("scoreboardB_drained", expQB.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
